// File: rtl/conv_frame_feeder.sv
// conv_frame_feeder: reads one 3x3-weight convolution job plus an NxN image
// from a 1-cycle-latency RAM and streams it out as header, 9 weights, N*N
// pixels over a valid/ready handshake. A 2-entry FIFO absorbs RAM returns
// while the consumer stalls. A returning word bypasses the empty FIFO, so
// the stream runs without bubbles.
module conv_frame_feeder #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 18,
  parameter int MAX_SIZE = 416
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [8:0]        i_img_size,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_w_base,
  input  logic [ADDR_W-1:0] i_img_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_chip_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int CNT_W = 19;

  typedef enum logic [1:0] {IDLE, HDR, STREAM, DONE} state_t;

  // Job descriptor latched at start; last_word is the index of the final
  // stream word (header = 0), which is also the total number of RAM reads.
  typedef struct packed {
    logic [8:0]        n;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] img_base;
    logic [CNT_W-1:0]  last_word;
  } job_t;

  state_t            state, state_nxt;
  job_t              job;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  wd_cnt;
  logic              rd_vld_q;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt;
  logic              err_q;

  logic              size_ok, start_ok, start_bad;
  logic [17:0]       nn_in;
  logic              xfer, push, pop, bypass, last_xfer;
  logic              rd_room, rd_more;
  logic [DATA_W-1:0] header;

  assign size_ok   = (i_img_size != '0) && (i_img_size <= 9'(MAX_SIZE));
  assign start_ok  = (state == IDLE) && i_start && size_ok;
  assign start_bad = (state == IDLE) && i_start && !size_ok;
  assign nn_in     = 18'(i_img_size) * 18'(i_img_size);

  // Header word carries the image side and mode in the low 11 bits.
  always_comb begin
    header       = '0;
    header[10:0] = {job.n, job.mode};
  end

  // Only issue a read when the word it returns is guaranteed a FIFO slot.
  assign rd_room   = ({1'b0, fifo_cnt} + {2'b0, rd_vld_q}) < 3'd2;
  assign rd_more   = rd_cnt != job.last_word;
  assign o_rd_en   = ((state == HDR) || (state == STREAM)) && rd_room && rd_more;
  assign o_rd_addr = o_rd_en ? rd_ptr : '0;

  assign xfer      = o_valid && i_ready;
  assign pop       = (state == STREAM) && xfer && (fifo_cnt != 2'd0);
  assign bypass    = (state == STREAM) && xfer && (fifo_cnt == 2'd0);
  assign push      = rd_vld_q && !bypass;
  assign last_xfer = (state == STREAM) && xfer && (wd_cnt == job.last_word);

  assign o_busy    = (state == HDR) || (state == STREAM);
  assign o_chip_en = (state != STREAM);
  assign o_done    = (state == DONE);
  assign o_err     = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and stream output: header in HDR, FIFO head (or the word
  // returning from RAM when the FIFO is empty) in STREAM.
  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    o_data    = '0;
    case (state)
      IDLE: if (start_ok) state_nxt = HDR;
      HDR: begin
        o_valid = 1'b1;
        o_data  = header;
        if (i_ready) state_nxt = STREAM;
      end
      STREAM: begin
        if (fifo_cnt != 2'd0) begin
          o_valid = 1'b1;
          o_data  = fifo_mem[fifo_rp];
        end else if (rd_vld_q) begin
          o_valid = 1'b1;
          o_data  = i_rd_data;
        end
        if (last_xfer) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, read address/count and transfer count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      job      <= '0;
      rd_ptr   <= '0;
      rd_cnt   <= '0;
      wd_cnt   <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_vld_q <= o_rd_en;
      err_q    <= start_bad;
      if (start_ok) begin
        job.n         <= i_img_size;
        job.mode      <= i_mode;
        job.img_base  <= i_img_base;
        job.last_word <= CNT_W'(nn_in) + CNT_W'(9);
        rd_ptr        <= i_w_base;
        rd_cnt        <= '0;
        wd_cnt        <= '0;
      end else begin
        if (o_rd_en) begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          // After weight 8 the read pointer jumps to the image.
          rd_ptr <= (rd_cnt == CNT_W'(8)) ? job.img_base : rd_ptr + ADDR_W'(1);
        end
        if (xfer) wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

  // 2-entry return FIFO; a bypassed word is consumed directly and never stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wp] <= i_rd_data;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_feeder.sv
// Bench for conv_frame_feeder: a table of jobs plus hand-written corner
// sequences, with a RAM model (RAM[a] = {salt, a}) and a reference stream
// built directly from the job parameters.
module tb_conv_frame_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [8:0]  i_img_size;
  logic [1:0]  i_mode;
  logic [17:0] i_w_base, i_img_base;
  logic        o_rd_en;
  logic [17:0] o_rd_addr;
  logic [63:0] i_rd_data = '0;
  logic [63:0] o_data;
  logic        o_valid, i_ready, o_chip_en, o_busy, o_done, o_err;

  conv_frame_feeder dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_img_size(i_img_size),
    .i_mode(i_mode), .i_w_base(i_w_base), .i_img_base(i_img_base),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_chip_en(o_chip_en), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job model state
  int          m_n;
  logic [1:0]  m_mode;
  logic [17:0] m_w, m_i;
  logic [31:0] salt = '0;
  bit          rand_ready = 1'b0;
  logic [63:0] exp_q[$];

  // Monitor observations
  logic [63:0] got[$];
  int cyc = 0;
  int rd_issued, data_xfers, done_cnt, err_cnt, busy_cnt, valid_cnt;
  int first_valid_cyc, start_cyc, last_xfer_cyc, err_cyc, done_cyc;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;

  typedef struct {
    int          n;
    logic [1:0]  mode;
    logic [17:0] wb;
    logic [17:0] ib;
    bit          rnd;
    bit          err;
    int          words;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ram_val(input logic [17:0] a);
    return {salt, 14'h0, a};
  endfunction

  function automatic logic [17:0] exp_addr(input int k);
    if (k < 9) return 18'(m_w + 18'(k));
    return 18'(m_i + 18'(k - 9));
  endfunction

  // Reference stream: header, 9 weights, N*N pixels in raster order.
  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back({53'h0, 9'(m_n), m_mode});
    for (int k = 0; k < 9; k++) exp_q.push_back(ram_val(18'(m_w + 18'(k))));
    for (int j = 0; j < m_n * m_n; j++) exp_q.push_back(ram_val(18'(m_i + 18'(j))));
  endfunction

  // Synchronous RAM, 1-cycle read latency
  always @(posedge clk) if (o_rd_en) i_rd_data <= ram_val(o_rd_addr);

  // Monitor: samples after the driver has set this cycle's inputs; a word
  // seen with o_valid && i_ready here transfers at the next rising edge.
  always @(negedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      if (i_start && start_cyc < 0) start_cyc = cyc;
      if (o_busy) busy_cnt++;
      if (o_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_stall) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_data", o_data, prev_data);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (o_busy) begin
        chk("buffered_le2", (rd_issued - data_xfers) <= 2, 1);
        chk("chip_en_busy", o_chip_en, got.size() == 0);
      end
      if (o_rd_en) begin
        chk("rd_addr", o_rd_addr, exp_addr(rd_issued));
        chk("rd_bound", rd_issued < 9 + m_n * m_n, 1);
        rd_issued++;
      end
      if (o_valid && i_ready) begin
        got.push_back(o_data);
        if (got.size() > 1) data_xfers++;
        last_xfer_cyc = cyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_lat", cyc, last_xfer_cyc + 1);
        chk("done_busy", o_busy, 0);
        chk("done_chip_en", o_chip_en, 1);
      end
      if (o_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clr();
    got.delete();
    rd_issued = 0; data_xfers = 0; done_cnt = 0; err_cnt = 0;
    busy_cnt = 0; valid_cnt = 0;
    first_valid_cyc = -1; start_cyc = -1; last_xfer_cyc = -1;
    err_cyc = -1; done_cyc = -1;
  endtask

  task automatic drive_ready();
    i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic launch(input int n, input logic [1:0] mode,
                        input logic [17:0] wb, input logic [17:0] ib);
    @(negedge clk);
    clr();
    m_n = n; m_mode = mode; m_w = wb; m_i = ib;
    if (n >= 1 && n <= 64) build_exp();
    i_start = 1'b1; i_img_size = 9'(n); i_mode = mode;
    i_w_base = wb; i_img_base = ib;
    drive_ready();
    @(negedge clk);
    // Scramble job inputs: the DUT must use its latched copies.
    i_start = 1'b0; i_img_size = 9'($urandom); i_mode = 2'($urandom);
    i_w_base = 18'($urandom); i_img_base = 18'($urandom);
    drive_ready();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      drive_ready();
      k++;
    end
    #3;
    chk("job_timeout", done_cnt > 0, 1);
  endtask

  task automatic check_job(input int words, input bit no_bubble);
    int nf = 0;
    chk("word_count", got.size(), words);
    for (int i = 0; i < got.size() && i < exp_q.size() && nf < 5; i++) begin
      if (got[i] !== exp_q[i]) nf++;
      chk("stream_word", got[i], exp_q[i]);
    end
    chk("done_once", done_cnt, 1);
    chk("no_err", err_cnt, 0);
    chk("hdr_lat", first_valid_cyc, start_cyc + 1);
    if (no_bubble) chk("no_bubble", done_cyc - start_cyc, words + 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", o_valid, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_data", o_data, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_chip_en", o_chip_en, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{6,   2'd3, 18'd1,   18'd10,  1'b0, 1'b0, 46};
    vt[1] = '{6,   2'd3, 18'd1,   18'd10,  1'b1, 1'b0, 46};
    vt[2] = '{0,   2'd1, 18'd1,   18'd10,  1'b0, 1'b1, 0};
    vt[3] = '{417, 2'd1, 18'd1,   18'd10,  1'b0, 1'b1, 0};
    vt[4] = '{1,   2'd0, 18'd100, 18'd200, 1'b0, 1'b0, 11};
    vt[5] = '{2,   2'd1, 18'd300, 18'd7,   1'b1, 1'b0, 14};
    vt[6] = '{511, 2'd2, 18'd5,   18'd6,   1'b0, 1'b1, 0};

    rst = 1'b0; i_start = 1'b0; i_img_size = '0; i_mode = '0;
    i_w_base = '0; i_img_base = '0; i_ready = 1'b1;
    m_n = 0; m_mode = '0; m_w = '0; m_i = '0;
    clr();
    #3;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b1;

    // Table of jobs
    for (int v = 0; v < 7; v++) begin
      rand_ready = vt[v].rnd;
      salt = '0;
      launch(vt[v].n, vt[v].mode, vt[v].wb, vt[v].ib);
      if (vt[v].err) begin
        repeat (4) @(negedge clk);
        #3;
        chk("err_pulses", err_cnt, 1);
        chk("err_lat", err_cyc, start_cyc + 1);
        chk("err_no_busy", busy_cnt, 0);
        chk("err_no_reads", rd_issued, 0);
        chk("err_no_valid", valid_cnt, 0);
      end else begin
        wait_done(3000);
        check_job(vt[v].words, !vt[v].rnd);
      end
    end

    // Randomized jobs
    for (int r = 0; r < 8; r++) begin
      rand_ready = 1'($urandom_range(0, 1));
      salt = $urandom;
      launch(int'($urandom_range(1, 9)), 2'($urandom), 18'($urandom), 18'($urandom));
      wait_done(3000);
      check_job(10 + m_n * m_n, !rand_ready);
    end
    salt = '0;

    // Second start while busy is ignored
    rand_ready = 1'b0;
    launch(1, 2'd2, 18'd50, 18'd60);
    repeat (2) @(negedge clk);
    i_start = 1'b1; i_img_size = 9'd6;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(500);
    check_job(11, 1'b0);
    repeat (4) @(negedge clk);
    #3;
    chk("no_restart_busy", o_busy, 0);
    chk("no_restart_done", done_cnt, 1);

    // N=1 with consumer stalled 5 cycles after the header
    rand_ready = 1'b0;
    launch(1, 2'd0, 18'd1, 18'd10);
    repeat (5) begin
      @(negedge clk);
      i_ready = 1'b0;
    end
    #3;
    chk("stall_outstanding", rd_issued - data_xfers, 2);
    chk("stall_hdr_only", got.size(), 1);
    wait_done(500);
    check_job(11, 1'b0);

    // Largest legal side is accepted, then aborted by reset
    launch(416, 2'd1, 18'd0, 18'd0);
    repeat (3) @(negedge clk);
    #3;
    chk("max_no_err", err_cnt, 0);
    chk("max_busy", o_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk);
    rst = 1'b1;

    // Reset at the 20th transfer of an N=6 job, then a fresh N=1 job
    launch(6, 2'd3, 18'd1, 18'd10);
    for (int k = 0; k < 200 && got.size() < 20; k++) begin
      @(negedge clk);
      drive_ready();
    end
    chk("reached_20", got.size(), 20);
    rst = 1'b0;
    #1;
    chk_reset_outs();
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    launch(1, 2'd1, 18'd1, 18'd10);
    wait_done(500);
    check_job(11, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
